// File: rtl/decode_stage.sv
// Decode stage: instruction register, 32x32 register file (R0 hardwired 0), registered operands and immediate.
// Define RF_BYPASS_EN for write-first register reads; the default build is read-first.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              IR_LdEn,
  input  logic              RF_WrEn,
  input  logic              RF_WrData_sel,
  input  logic              RF_B_sel,
  input  logic [1:0]        ImmExt,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [31:0]       Immed,
  output logic [5:0]        Opcode,
  output logic [5:0]        Func
);

  logic [31:0]       ir;
  logic [DATA_W-1:0] rf [REG_CNT];

  logic [4:0]        rs_addr;
  logic [4:0]        rd_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        b_addr;
  logic [15:0]       imm;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [31:0]       imm_ext;

  assign rs_addr = ir[25:21];
  assign rd_addr = ir[20:16];
  assign rt_addr = ir[15:11];
  assign imm     = ir[15:0];
  assign b_addr  = RF_B_sel ? rd_addr : rt_addr;
  assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;

  assign Opcode  = ir[31:26];
  assign Func    = ir[5:0];

  always_comb begin
    rd_a = (rs_addr == 5'd0) ? '0 : rf[rs_addr];
    rd_b = (b_addr  == 5'd0) ? '0 : rf[b_addr];
`ifdef RF_BYPASS_EN
    // Write-first: a read of the register being written sees the new data.
    if (RF_WrEn && (rd_addr != 5'd0) && (rd_addr == rs_addr)) rd_a = wr_data;
    if (RF_WrEn && (rd_addr != 5'd0) && (rd_addr == b_addr))  rd_b = wr_data;
`endif
  end

  always_comb begin
    imm_ext = '0;
    case (ImmExt)
      2'b00:   imm_ext = {{16{imm[15]}}, imm};
      2'b01:   imm_ext = {16'h0000, imm};
      2'b10:   imm_ext = {imm, 16'h0000};
      default: imm_ext = {{14{imm[15]}}, imm, 2'b00};
    endcase
  end

  // Write address is taken from the pre-edge IR, so a simultaneous IR load
  // still retires the write into the old instruction's rd.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ir    <= '0;
      RF_A  <= '0;
      RF_B  <= '0;
      Immed <= '0;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else begin
      if (IR_LdEn) ir <= Instr;
      if (RF_WrEn && (rd_addr != 5'd0)) rf[rd_addr] <= wr_data;
      RF_A  <= rd_a;
      RF_B  <= rd_b;
      Immed <= imm_ext;
    end
  end

endmodule
